// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path: legal segment codes,
// the illegal-digit marker and the capture FSM state encoding.
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g} on bits [6:0].
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam logic [3:0] SEG_ERR_VAL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

endpackage

// File: rtl/seven_segment_reader_if.sv
// Frame hand-off bus from the segment reader to its consumer.
// Valid/ready: a frame moves on every rising edge where out_valid && out_ready;
// once out_valid is high, digits/digit_err hold steady until that transfer.
interface seven_segment_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output out_valid,
    output digits,
    output digit_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  digits,
    input  digit_err,
    output out_ready
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern to BCD decoder; anything that is not a
// legal 0-9 code decodes to SEG_ERR_VAL with err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       err,
  output logic [3:0] bcd
);

  always_comb begin
    err = 1'b0;
    bcd = SEG_ERR_VAL;
    case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed 7-segment bus: waits for each strobed digit to
// settle, decodes it, and hands complete frames out over a valid/ready bus.
module seven_segment_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  seven_segment_reader_if.master frame,
  output logic                  overrun,
  output state_t                fsm_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] sel_q, sel_p;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  capture, restart;
  logic                  one_hot, changed, frame_done;
  logic [4*NUM_DIGITS-1:0] slot_bcd;
  logic [NUM_DIGITS-1:0]   slot_err, mask;
  logic                  dec_err;
  logic [3:0]            dec_bcd;

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .err     (dec_err),
    .bcd     (dec_bcd)
  );

  assign one_hot    = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  assign changed    = {seg_q, sel_q} != {seg_p, sel_p};
  assign frame_done = &mask;
  assign fsm_state  = state;

  // seg_p/sel_p hold the previous registered sample for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= '0;
      sel_q <= '0;
      seg_p <= '0;
      sel_p <= '0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    restart = 1'b0;
    case (state)
      ST_IDLE:     restart = 1'b1;
      ST_SETTLE: begin
        if (changed) begin
          restart = 1'b1;
        end else begin
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
          if (cnt >= CNT_MAX - 1'b1) begin
            capture = 1'b1;
            state_n = ST_CAPTURED;
          end
        end
      end
      ST_CAPTURED: restart = changed;
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    // A new dwell starts counting at 1; a single-cycle setting captures at once.
    if (restart) begin
      if (!one_hot) begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end else if (STABLE_CYCLES == 1) begin
        capture = 1'b1;
        state_n = ST_CAPTURED;
        cnt_n   = CNT_ONE;
      end else begin
        state_n = ST_SETTLE;
        cnt_n   = CNT_ONE;
      end
    end
  end

  // A completed mask is consumed on the edge after it fills; a capture landing
  // on that same edge starts the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_bcd <= '0;
      slot_err <= '0;
      mask     <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && sel_q[k]) begin
          slot_bcd[4*k +: 4] <= dec_bcd;
          slot_err[k]        <= dec_err;
        end
      end
      mask <= (frame_done ? '0 : mask) | (capture ? sel_q : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame.out_valid <= 1'b0;
      frame.digits    <= '0;
      frame.digit_err <= '0;
      overrun         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (frame.out_valid && !frame.out_ready) begin
          overrun <= 1'b1;
        end else begin
          frame.out_valid <= 1'b1;
          frame.digits    <= slot_bcd;
          frame.digit_err <= slot_err;
        end
      end else if (frame.out_valid && frame.out_ready) begin
        frame.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with NUM_DIGITS=4, STABLE_CYCLES=8.
module tb_seven_segment_reader;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int W  = 5 * ND;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic          overrun;
  state_t        fsm_state;

  seven_segment_reader_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .frame     (bus),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int ovr_cnt = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic [15:0] digits;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input int k, input logic [6:0] seg, input int cycles);
    dig_sel = ND'(1) << k;
    seg_in  = seg;
    tick(cycles);
  endtask

  task automatic go_idle(input int n);
    dig_sel = '0;
    seg_in  = '0;
    tick(n);
  endtask

  task automatic send_frame(input logic [27:0] segs);
    for (int k = 0; k < ND; k++) send_digit(k, segs[7*k +: 7], 12);
  endtask

  // Scoreboard: every transfer is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) vld_cnt++;
      if (overrun) ovr_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got %h expected none", {bus.digit_err, bus.digits});
        end else begin
          check("frame", 32'({bus.digit_err, bus.digits}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{segs: {SEG_4, SEG_3, SEG_2, SEG_1}, digits: 16'h4321, err: 4'b0000};
    vecs[1] = '{segs: {SEG_7, SEG_6, SEG_5, SEG_0}, digits: 16'h7650, err: 4'b0000};
    vecs[2] = '{segs: {SEG_1, SEG_0, SEG_9, SEG_8}, digits: 16'h1098, err: 4'b0000};
    vecs[3] = '{segs: {SEG_3, 7'h7C, SEG_1, SEG_1}, digits: 16'h3F11, err: 4'b0100};

    // Reset with live inputs.
    reset = 1'b1;
    seg_in = SEG_1;
    dig_sel = 4'b0001;
    bus.out_ready = 1'b1;
    tick(3);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_digits", 32'(bus.digits), 0);
    check("rst_err", 32'(bus.digit_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick(SC);
    check("no_early_capture", 32'(fsm_state), 32'(ST_SETTLE));
    tick(1);
    check("capture_latency", 32'(fsm_state), 32'(ST_CAPTURED));
    reset = 1'b1;
    go_idle(2);
    reset = 1'b0;
    go_idle(2);

    // Table of complete frames, consumer always ready.
    for (int v = 0; v < 4; v++) begin
      vld_cnt = 0;
      ovr_cnt = 0;
      exp_q.push_back({vecs[v].err, vecs[v].digits});
      send_frame(vecs[v].segs);
      go_idle(4);
      check($sformatf("vec%0d_valid_cycles", v), 32'(vld_cnt), 1);
      check($sformatf("vec%0d_overrun", v), 32'(ovr_cnt), 0);
    end

    // A 7-cycle dwell is too short; the following 8-cycle dwell wins.
    vld_cnt = 0;
    exp_q.push_back({4'b0000, 16'h1115});
    send_digit(0, SEG_3, 7);
    send_digit(0, SEG_5, 1);
    check("short_dwell_no_capture", 32'(fsm_state), 32'(ST_SETTLE));
    tick(7);
    check("dwell8_not_yet", 32'(fsm_state), 32'(ST_SETTLE));
    send_digit(1, SEG_1, 1);
    check("dwell8_captured", 32'(fsm_state), 32'(ST_CAPTURED));
    tick(11);
    send_digit(2, SEG_1, 12);
    send_digit(3, SEG_1, 12);
    go_idle(4);
    check("dwell_valid_cycles", 32'(vld_cnt), 1);

    // Multi-hot and zero strobes never capture.
    vld_cnt = 0;
    exp_q.push_back({4'b0000, 16'h3210});
    send_digit(0, SEG_0, 12);
    send_digit(1, SEG_1, 12);
    dig_sel = 4'b0011;
    seg_in  = SEG_8;
    tick(50);
    check("multihot_idle", 32'(fsm_state), 32'(ST_IDLE));
    go_idle(50);
    check("zero_sel_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("no_frame_yet", 32'(vld_cnt), 0);
    send_digit(2, SEG_2, 12);
    send_digit(3, SEG_3, 12);
    go_idle(4);
    check("partial_valid_cycles", 32'(vld_cnt), 1);

    // Backpressure: second frame is dropped with an overrun pulse.
    bus.out_ready = 1'b0;
    ovr_cnt = 0;
    exp_q.push_back({4'b0000, 16'h1111});
    send_frame({SEG_1, SEG_1, SEG_1, SEG_1});
    go_idle(3);
    check("held_valid", 32'(bus.out_valid), 1);
    send_frame({SEG_0, SEG_0, SEG_0, SEG_0});
    go_idle(3);
    check("overrun_pulses", 32'(ovr_cnt), 1);
    check("held_valid2", 32'(bus.out_valid), 1);
    check("held_digits", 32'(bus.digits), 32'h1111);
    check("held_err", 32'(bus.digit_err), 0);
    bus.out_ready = 1'b1;
    tick(1);
    check("valid_drop_after_xfer", 32'(bus.out_valid), 0);
    go_idle(2);

    // Reset mid-frame discards the two captured digits.
    vld_cnt = 0;
    send_digit(0, SEG_1, 12);
    send_digit(1, SEG_1, 12);
    reset = 1'b1;
    go_idle(2);
    reset = 1'b0;
    go_idle(2);
    send_digit(2, SEG_2, 12);
    send_digit(3, SEG_3, 12);
    go_idle(5);
    check("reset_clears_mask", 32'(vld_cnt), 0);
    exp_q.push_back({4'b0000, 16'h3250});
    send_digit(0, SEG_0, 12);
    send_digit(1, SEG_5, 12);
    go_idle(5);
    check("post_reset_frame", 32'(vld_cnt), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
